nonce_collector_hub: RTL
========================

NONCE_COLLECTOR_HUB -- requirements
Module: nonce_collector_hub

Interface
REQ-001 SHALL have parameter SLAVES, default 4, number of nonce sources (1..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, result FIFO entries (power of two, 2..64).
REQ-003 SHALL have parameter NONCE_W, default 32, nonce width in bits.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port slave_nonces  input  SLAVES*NONCE_W  nonce of slave i at bits [i*NONCE_W +: NONCE_W].
REQ-007 SHALL have port new_nonces  input  SLAVES  per-slave valid level; a rising edge marks a new nonce.
REQ-008 SHALL have port serial_busy  input  1  transmitter busy.
REQ-009 SHALL have port serial_send  output  1  one-cycle transmit strobe.
REQ-010 SHALL have port golden_nonce  output  NONCE_W  word under transmission.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port drop_count  output  16  saturating count of nonces lost to capture overrun.

Function
REQ-013 Per slave: new_nonces registered once; a rising edge (prev 0, now 1) SHALL latch slave_nonces slice into a capture register and set pending[i], in the cycle after the edge.
REQ-014 Edge on slave i while pending[i]=1 SHALL leave the held nonce unchanged and increment drop_count (saturate at 16'hFFFF).
REQ-015 Arbiter SHALL grant at most one pending slave per cycle, round-robin, starting from the index after the last grant; grant only when FIFO not full.
REQ-016 Grant SHALL write the held nonce to the FIFO and clear pending[i] in the same cycle; a simultaneous new edge on the granted slave SHALL be captured, not dropped.
REQ-017 FIFO full SHALL stall grants; pending flags hold; no FIFO data lost.
REQ-018 Transmit FSM states IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> SEND when FIFO not empty and serial_busy=0; on entry golden_nonce loads FIFO head and FIFO pops.
REQ-020 SEND: serial_send=1 for exactly one cycle, then -> WAIT_BUSY.
REQ-021 WAIT_BUSY -> WAIT_DONE when serial_busy=1; if serial_busy stays 0 for 4 cycles, -> IDLE (transmitter assumed done).
REQ-022 WAIT_DONE -> IDLE when serial_busy=0.
REQ-023 golden_nonce SHALL be stable from SEND until the next SEND.
REQ-024 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 Latency: edge on new_nonces to serial_send, idle transmitter, empty FIFO, no contention = 4 cycles.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear pending, edge history, FIFO pointers, fifo_count, drop_count, RR pointer (to slave 0), FSM to IDLE, serial_send=0, golden_nonce=0.
REQ-027 Reset mid-transmission SHALL abandon the word; no serial_send until a new nonce arrives after release.
REQ-028 new_nonces already high at reset release SHALL not count as an edge.

Configuration
REQ-029 Macro NONCE_DEDUP_EN defined: a granted nonce equal to the last nonce written to the FIFO (since reset) SHALL be discarded (pending cleared, no push, drop_count unchanged).
REQ-030 Macro NONCE_DEDUP_EN undefined: every granted nonce SHALL be pushed; no comparator synthesised.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding and the WAIT_BUSY timeout constant (4).
REQ-032 FIFO SHALL be a sub-module nonce_fifo (parameters NONCE_W, FIFO_DEPTH; push, pop, full, empty, count).

Verification
REQ-033 Single edge slave 2, nonce 32'hDEADBEEF, busy tied 0 -> serial_send pulse 4 cycles later, golden_nonce=32'hDEADBEEF.
REQ-034 Edges on slaves 0..3 same cycle, busy held 100 cycles per word -> transmitted order 0,1,2,3; drop_count=0.
REQ-035 Slave 1 edges twice while transmitter busy and FIFO full (FIFO_DEPTH=2) -> second edge counted, drop_count=1.
REQ-036 Transmitter never asserts busy -> FSM returns to IDLE after 4 WAIT_BUSY cycles, next word sent.
REQ-037 With NONCE_DEDUP_EN: slave 0 then slave 1 both report 32'h12345678 -> one serial_send; without macro -> two.
REQ-038 rst_n low during WAIT_DONE with 3 words queued -> fifo_count=0, serial_send=0 until a new edge after release.

Source files
------------

// File: rtl/nonce_collector_hub_pkg.sv
// -----------------------------------------------------------------------------
// nonce_collector_hub_pkg
// Shared definitions for the nonce collector hub:
//   - tx_state_t   : transmit FSM state encoding
//   - BUSY_TIMEOUT : cycles WAIT_BUSY waits for serial_busy before assuming the
//                    transmitter already finished
//   - sat_add16    : saturating adder used by the drop counter
// -----------------------------------------------------------------------------
package nonce_collector_hub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

    localparam int unsigned BUSY_TIMEOUT = 4;
    localparam int unsigned TO_CNT_W     = 3;
    localparam logic [15:0] DROP_MAX     = 16'hFFFF;

    // Add a small increment to a 16-bit counter, clamping at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] value,
                                              input logic [4:0]  inc);
        logic [16:0] sum;
        sum = {1'b0, value} + {12'd0, inc};
        return sum[16] ? DROP_MAX : sum[15:0];
    endfunction

endpackage

// File: rtl/nonce_collector_hub_fifo.sv
// -----------------------------------------------------------------------------
// nonce_fifo
// Synchronous single-clock FIFO holding captured nonces.
// Parameters: NONCE_W (word width), FIFO_DEPTH (power of two, 2..64).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request (ignored when full)
//   pop, pop_data       read request (ignored when empty); pop_data is the head
//   full, empty, count  occupancy status (count is $clog2(FIFO_DEPTH)+1 bits)
// -----------------------------------------------------------------------------
module nonce_fifo
    import nonce_collector_hub_pkg::*;
#(
    parameter int NONCE_W    = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [NONCE_W-1:0]            push_data,
    input  logic                          pop,
    output logic [NONCE_W-1:0]            pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [NONCE_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign full      = (count_r == CW'(FIFO_DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array; data needs no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH since the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/nonce_collector_hub.sv
// -----------------------------------------------------------------------------
// nonce_collector_hub
// Collects nonces from SLAVES sources, queues them in a FIFO and hands them one
// at a time to a serial transmitter.
// Parameters: SLAVES (1..16), FIFO_DEPTH (power of two, 2..64), NONCE_W.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   slave_nonces    packed nonces, slave i at [i*NONCE_W +: NONCE_W]
//   new_nonces      per-slave valid level; a 0->1 transition is a new nonce
//   serial_busy     transmitter busy
//   serial_send     one-cycle transmit strobe
//   golden_nonce    word under transmission
//   fifo_count      FIFO occupancy
//   drop_count      saturating count of nonces lost to capture overrun
// Build option: define NONCE_DEDUP_EN to discard a granted nonce equal to the
// last nonce written to the FIFO since reset.
// -----------------------------------------------------------------------------
module nonce_collector_hub
    import nonce_collector_hub_pkg::*;
#(
    parameter int SLAVES     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int NONCE_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SLAVES*NONCE_W-1:0]     slave_nonces,
    input  logic [SLAVES-1:0]             new_nonces,
    input  logic                          serial_busy,
    output logic                          serial_send,
    output logic [NONCE_W-1:0]            golden_nonce,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   drop_count
);

    localparam int IW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    // Input history and capture state
    logic                             hist_valid_r;
    logic [SLAVES-1:0]                nn_r;
    logic [SLAVES-1:0]                nn_prev_r;
    logic [SLAVES*NONCE_W-1:0]        sn_r;
    logic [SLAVES-1:0][NONCE_W-1:0]   held_r;
    logic [SLAVES-1:0]                pending_r;
    logic [15:0]                      drop_count_r;
    logic [IW-1:0]                    rr_ptr_r;

    logic [SLAVES-1:0]                edge_s;
    logic [SLAVES-1:0]                drop_vec_s;
    logic [4:0]                       drop_inc_s;
    logic [SLAVES-1:0]                grant_s;
    logic                             grant_vld_s;
    logic [IW-1:0]                    grant_idx_s;
    logic [IW-1:0]                    rr_next_s;
    logic                             push_s;

    // FIFO interface
    logic [NONCE_W-1:0]               fifo_head_s;
    logic                             fifo_full_s;
    logic                             fifo_empty_s;
    logic                             pop_s;

    // Transmit FSM
    tx_state_t                        state_r;
    tx_state_t                        state_next_s;
    logic [TO_CNT_W-1:0]              to_cnt_r;
    logic [TO_CNT_W-1:0]              to_cnt_next_s;
    logic                             serial_send_r;
    logic [NONCE_W-1:0]               golden_r;

    assign edge_s = nn_r & ~nn_prev_r;

    // Register the valid levels and data once. On the first cycle after reset
    // both history stages load the same value, so a level already high at
    // release is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_valid_r <= 1'b0;
            nn_r         <= '0;
            nn_prev_r    <= '0;
            sn_r         <= '0;
        end else begin
            hist_valid_r <= 1'b1;
            nn_r         <= new_nonces;
            sn_r         <= slave_nonces;
            if (hist_valid_r) begin
                nn_prev_r <= nn_r;
            end else begin
                nn_prev_r <= new_nonces;
            end
        end
    end

    // An edge is dropped only if the slave still holds an ungranted nonce;
    // an edge coinciding with its own grant is captured.
    always_comb begin
        drop_vec_s = '0;
        drop_inc_s = 5'd0;
        for (int i = 0; i < SLAVES; i++) begin
            drop_vec_s[i] = edge_s[i] & pending_r[i] & ~grant_s[i];
            drop_inc_s    = drop_inc_s + {4'd0, drop_vec_s[i]};
        end
    end

    // Round-robin arbiter: search starts at rr_ptr_r, stalls while FIFO is full.
    always_comb begin
        logic [IW-1:0] idx;
        idx         = '0;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        if (!fifo_full_s) begin
            for (int k = 0; k < SLAVES; k++) begin
                idx = IW'((int'(rr_ptr_r) + k) % SLAVES);
                if (!grant_vld_s && pending_r[idx]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = idx;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            grant_vld_s = 1'b0;
        end
        grant_s   = grant_vld_s ? (SLAVES'(1) << grant_idx_s) : '0;
        rr_next_s = (grant_idx_s == IW'(SLAVES - 1)) ? '0 : grant_idx_s + IW'(1);
    end

`ifdef NONCE_DEDUP_EN
    logic [NONCE_W-1:0] last_pushed_r;
    logic               last_vld_r;
    logic               dup_s;

    assign dup_s  = last_vld_r && (held_r[grant_idx_s] == last_pushed_r);
    assign push_s = grant_vld_s & ~dup_s;

    // Remember the last word written to the FIFO for duplicate suppression.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pushed_r <= '0;
            last_vld_r    <= 1'b0;
        end else if (push_s) begin
            last_pushed_r <= held_r[grant_idx_s];
            last_vld_r    <= 1'b1;
        end
    end
`else
    assign push_s = grant_vld_s;
`endif

    // Capture registers, pending flags, drop counter and RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_r       <= '0;
            pending_r    <= '0;
            drop_count_r <= 16'd0;
            rr_ptr_r     <= '0;
        end else begin
            for (int i = 0; i < SLAVES; i++) begin
                if (edge_s[i] && !drop_vec_s[i]) begin
                    held_r[i]    <= sn_r[i*NONCE_W +: NONCE_W];
                    pending_r[i] <= 1'b1;
                end else if (grant_s[i]) begin
                    pending_r[i] <= 1'b0;
                end
            end
            drop_count_r <= sat_add16(drop_count_r, drop_inc_s);
            if (grant_vld_s) begin
                rr_ptr_r <= rr_next_s;
            end
        end
    end

    nonce_fifo #(
        .NONCE_W    (NONCE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (held_r[grant_idx_s]),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count)
    );

    // Transmit FSM next-state logic; the pop happens on the IDLE->SEND move.
    always_comb begin
        state_next_s  = state_r;
        to_cnt_next_s = to_cnt_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && !serial_busy) begin
                    state_next_s = ST_SEND;
                    pop_s        = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_next_s  = ST_WAIT_BUSY;
                to_cnt_next_s = '0;
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never raises busy is assumed done after
                // BUSY_TIMEOUT cycles here.
                if (serial_busy) begin
                    state_next_s = ST_WAIT_DONE;
                end else if (to_cnt_r == TO_CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    to_cnt_next_s = to_cnt_r + TO_CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!serial_busy) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Transmit FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            to_cnt_r      <= '0;
            serial_send_r <= 1'b0;
            golden_r      <= '0;
        end else begin
            state_r       <= state_next_s;
            to_cnt_r      <= to_cnt_next_s;
            serial_send_r <= (state_next_s == ST_SEND);
            if (pop_s) begin
                golden_r <= fifo_head_s;
            end
        end
    end

    assign serial_send  = serial_send_r;
    assign golden_nonce = golden_r;
    assign drop_count   = drop_count_r;

endmodule
